hazard_stall_ctrl: RTL and testbench

Pipeline hazard and stall controller for the 5-stage MIPS pipeline; the producer-side counterpart of the EX forwarding unit. It handles the cases forwarding cannot cover. For a load-use hazard it inserts a one-cycle bubble into ID/EX and holds PC and IF/ID. While the data memory has not acknowledged a MEM-stage access, it freezes the whole pipeline. A watchdog flags a memory access that never completes.

---
 rtl/hazard_stall_ctrl.sv | 142 ++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use bubble insertion, data-memory wait freeze and
// memory-timeout watchdog for the 5-stage MIPS pipeline.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined;
// otherwise LU_STALL_CNT and MEM_STALL_CNT are tied to zero.
module hazard_stall_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ID_RS,
  input  logic [4:0]       ID_RT,
  input  logic             ID_RT_USED,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_RT,
  input  logic             MEM_REQ,
  input  logic             MEM_ACK,
  output logic             PC_WRITE,
  output logic             IFID_WRITE,
  output logic             IDEX_BUBBLE,
  output logic             PIPE_FREEZE,
  output logic             MEM_TIMEOUT,
  output logic [1:0]       STALL_STATE,
  output logic [CNT_W-1:0] LU_STALL_CNT,
  output logic [CNT_W-1:0] MEM_STALL_CNT
);

  localparam int WCNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_WAIT = 2'b01,
    ST_ERR  = 2'b10
  } state_t;

  state_t            state;
  logic [WCNT_W-1:0] wait_cnt;
  logic              lu;
  logic              mw;

  // Load in EX feeds a source of the instruction in ID; r0 is never a hazard.
  assign lu = EX_MemRead && (EX_RT != 5'd0) &&
              ((EX_RT == ID_RS) || (ID_RT_USED && (EX_RT == ID_RT)));
  // Data memory is busy with an access it has not finished.
  assign mw = MEM_REQ && !MEM_ACK;

  // Stall FSM with watchdog; the first frozen RUN cycle counts as cycle 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (mw) begin
            state    <= ST_WAIT;
            wait_cnt <= WCNT_W'(1);
          end
        end
        ST_WAIT: begin
          if (MEM_ACK) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WCNT_LAST) begin
            state <= ST_ERR;
          end else begin
            wait_cnt <= wait_cnt + WCNT_W'(1);
          end
        end
        ST_ERR: begin
          state <= ST_ERR;
        end
        default: begin
          state    <= ST_RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  // Zero-latency stall decode; reset forces the non-stall values.
  always_comb begin
    PC_WRITE    = 1'b1;
    IFID_WRITE  = 1'b1;
    IDEX_BUBBLE = 1'b0;
    PIPE_FREEZE = 1'b0;
    if (!rst) begin
      case (state)
        ST_RUN, ST_WAIT: begin
          // Freeze wins over a bubble: ID/EX is held, LU is re-checked later.
          if ((state == ST_RUN) ? mw : !MEM_ACK) begin
            PIPE_FREEZE = 1'b1;
            PC_WRITE    = 1'b0;
            IFID_WRITE  = 1'b0;
          end else if (lu) begin
            IDEX_BUBBLE = 1'b1;
            PC_WRITE    = 1'b0;
            IFID_WRITE  = 1'b0;
          end
        end
        ST_ERR: begin
          PIPE_FREEZE = 1'b1;
          PC_WRITE    = 1'b0;
          IFID_WRITE  = 1'b0;
        end
        default: begin
          PC_WRITE   = 1'b1;
          IFID_WRITE = 1'b1;
        end
      endcase
    end
  end

  assign STALL_STATE = rst ? 2'b00 : state;
  assign MEM_TIMEOUT = !rst && (state == ST_ERR);

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] lu_cnt;
  logic [CNT_W-1:0] mem_cnt;

  // Saturating stall-cycle counters; freeze cycles spent in ERR are not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lu_cnt  <= '0;
      mem_cnt <= '0;
    end else begin
      if (IDEX_BUBBLE && (lu_cnt != {CNT_W{1'b1}}))
        lu_cnt <= lu_cnt + CNT_W'(1);
      if (PIPE_FREEZE && (state != ST_ERR) && (mem_cnt != {CNT_W{1'b1}}))
        mem_cnt <= mem_cnt + CNT_W'(1);
    end
  end

  assign LU_STALL_CNT  = lu_cnt;
  assign MEM_STALL_CNT = mem_cnt;
`else
  assign LU_STALL_CNT  = '0;
  assign MEM_STALL_CNT = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl (TIMEOUT_CYCLES=4, CNT_W=4).
// Counter expectations follow HAZARD_PERF_CNT_EN.
module tb_hazard_stall_ctrl;
  localparam int TO = 4;
  localparam int CW = 4;

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [CW-1:0] EXP_LU_SAT = 4'd15;
  localparam logic [CW-1:0] EXP_MEM3   = 4'd3;
`else
  localparam logic [CW-1:0] EXP_LU_SAT = 4'd0;
  localparam logic [CW-1:0] EXP_MEM3   = 4'd0;
`endif

  // {PC_WRITE, IFID_WRITE, IDEX_BUBBLE, PIPE_FREEZE, MEM_TIMEOUT}
  localparam logic [4:0] RUNO = 5'b11000;
  localparam logic [4:0] BUB  = 5'b00100;
  localparam logic [4:0] FRZ  = 5'b00010;
  localparam logic [4:0] ERRO = 5'b00011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
  logic id_rt_used = 1'b0, ex_memread = 1'b0, mem_req = 1'b0, mem_ack = 1'b0;
  logic pc_write, ifid_write, idex_bubble, pipe_freeze, mem_timeout;
  logic [1:0] stall_state;
  logic [CW-1:0] lu_stall_cnt, mem_stall_cnt;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [4:0]    o;
    logic [1:0]    st;
    logic          cc;
    logic [CW-1:0] lu;
    logic [CW-1:0] mem;
    string         nm;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .ID_RS(id_rs), .ID_RT(id_rt), .ID_RT_USED(id_rt_used),
    .EX_MemRead(ex_memread), .EX_RT(ex_rt),
    .MEM_REQ(mem_req), .MEM_ACK(mem_ack),
    .PC_WRITE(pc_write), .IFID_WRITE(ifid_write), .IDEX_BUBBLE(idex_bubble),
    .PIPE_FREEZE(pipe_freeze), .MEM_TIMEOUT(mem_timeout),
    .STALL_STATE(stall_state),
    .LU_STALL_CNT(lu_stall_cnt), .MEM_STALL_CNT(mem_stall_cnt)
  );

  // Drive one cycle of stimulus just after the edge and queue its expectation.
  task automatic drvc(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                      input logic rtu, input logic mr, input logic [4:0] ert,
                      input logic req, input logic ack,
                      input logic [4:0] o, input logic [1:0] st,
                      input logic cc, input logic [CW-1:0] lu, input logic [CW-1:0] mem,
                      input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; id_rs = rs; id_rt = rt; id_rt_used = rtu;
    ex_memread = mr; ex_rt = ert; mem_req = req; mem_ack = ack;
    e.o = o; e.st = st; e.cc = cc; e.lu = lu; e.mem = mem; e.nm = nm;
    sb.push_back(e);
  endtask

  task automatic drv(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                     input logic rtu, input logic mr, input logic [4:0] ert,
                     input logic req, input logic ack,
                     input logic [4:0] o, input logic [1:0] st, input string nm);
    drvc(r, rs, rt, rtu, mr, ert, req, ack, o, st, 1'b0, '0, '0, nm);
  endtask

  // Monitor: mid-cycle, pop one expectation and compare the live outputs.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        exp_t e;
        logic [4:0] got;
        e = sb.pop_front();
        got = {pc_write, ifid_write, idex_bubble, pipe_freeze, mem_timeout};
        tests++;
        if (got !== e.o || stall_state !== e.st) begin
          fails++;
          $display("FAIL %s: got pc/ifid/bub/frz/tmo=%b state=%b, want %b state=%b",
                   e.nm, got, stall_state, e.o, e.st);
        end else begin
          $display("[TB] ok %s: outs=%b state=%b", e.nm, got, stall_state);
        end
        if (e.cc) begin
          tests++;
          if (lu_stall_cnt !== e.lu || mem_stall_cnt !== e.mem) begin
            fails++;
            $display("FAIL %s_cnt: got lu=%0d mem=%0d, want lu=%0d mem=%0d",
                     e.nm, lu_stall_cnt, mem_stall_cnt, e.lu, e.mem);
          end else begin
            $display("[TB] ok %s_cnt: lu=%0d mem=%0d", e.nm, lu_stall_cnt, mem_stall_cnt);
          end
        end
      end
    end
  end

  initial begin
    // Reset override, then freeze appears once rst drops; ACK with LU -> bubble.
    drv(1, 5'd5, 5'd0, 0, 1, 5'd5, 1, 0, RUNO, 2'b00, "rst_override");
    drv(0, 5'd5, 5'd0, 0, 1, 5'd5, 1, 0, FRZ,  2'b00, "rst_release_frz_over_lu");
    drv(0, 5'd5, 5'd0, 0, 1, 5'd5, 0, 1, BUB,  2'b01, "ack_then_lu_bubble");
    drv(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, RUNO, 2'b00, "idle");
    // Load-use
    drv(0, 5'd5, 5'd0, 0, 1, 5'd5, 0, 0, BUB,  2'b00, "lu_rs");
    drv(0, 5'd5, 5'd0, 0, 0, 5'd5, 0, 0, RUNO, 2'b00, "lu_one_cycle");
    drv(0, 5'd0, 5'd0, 0, 1, 5'd0, 0, 0, RUNO, 2'b00, "lu_r0");
    drv(0, 5'd1, 5'd5, 0, 1, 5'd5, 0, 0, RUNO, 2'b00, "lu_rt_unused");
    drv(0, 5'd1, 5'd5, 1, 1, 5'd5, 0, 0, BUB,  2'b00, "lu_rt_used");
    // Memory wait: 3 frozen cycles then ACK
    drv(0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0, FRZ,  2'b00, "mw_c1");
    drv(0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0, FRZ,  2'b01, "mw_c2");
    drv(0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0, FRZ,  2'b01, "mw_c3");
    drv(0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 1, RUNO, 2'b01, "mw_ack");
    drv(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, RUNO, 2'b00, "mw_back_run");
    // Timeout: ACK never comes
    drv(0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0, FRZ,  2'b00, "to_c1");
    drv(0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0, FRZ,  2'b01, "to_c2");
    drv(0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0, FRZ,  2'b01, "to_c3");
    drv(0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0, FRZ,  2'b01, "to_c4");
    drv(0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0, ERRO, 2'b10, "to_err");
    drv(0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 1, ERRO, 2'b10, "to_err_ack_ignored");
    drv(0, 5'd5, 5'd0, 0, 1, 5'd5, 0, 0, ERRO, 2'b10, "to_err_held");
    drv(1, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0, RUNO, 2'b00, "to_err_rst");
    drv(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, RUNO, 2'b00, "to_after_rst");
    // ACK in the TIMEOUT_CYCLES-th cycle: no error
    drv(0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0, FRZ,  2'b00, "to4_c1");
    drv(0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0, FRZ,  2'b01, "to4_c2");
    drv(0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0, FRZ,  2'b01, "to4_c3");
    drv(0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 1, RUNO, 2'b01, "to4_ack");
    drv(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, RUNO, 2'b00, "to4_no_err");
    // Asynchronous reset mid-WAIT
    drv(0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0, FRZ,  2'b00, "wrst_c1");
    drv(0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0, FRZ,  2'b01, "wrst_c2");
    drv(1, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0, RUNO, 2'b00, "wrst_rst");
    drv(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, RUNO, 2'b00, "wrst_after");
    // Counters: 3 freeze cycles, then 20 bubbles (saturates a 4-bit counter)
    drvc(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, RUNO, 2'b00, 1'b1, '0, '0, "cnt_rst");
    drv(0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0, FRZ,  2'b00, "cnt_mw1");
    drv(0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0, FRZ,  2'b01, "cnt_mw2");
    drv(0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0, FRZ,  2'b01, "cnt_mw3");
    drvc(0, 5'd0, 5'd0, 0, 0, 5'd0, 1, 1, RUNO, 2'b01, 1'b1, '0, EXP_MEM3, "cnt_mem3");
    for (int i = 0; i < 20; i++)
      drv(0, 5'd5, 5'd0, 0, 1, 5'd5, 0, 0, BUB, 2'b00, "cnt_bubble");
    drvc(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, RUNO, 2'b00, 1'b1, EXP_LU_SAT, EXP_MEM3, "cnt_lu_sat");

    // Let the monitor drain the scoreboard, bounded.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: got %0d pending entries, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
